// File: rtl/vx_tensor_pkg.sv
// Shared types and helpers for the integer tensor dot-product unit.
// sat_trunc works on a fixed MAX_ACC_W+1 container, so ACC_W is limited to MAX_ACC_W.
package vx_tensor_pkg;

    localparam int unsigned MAX_ACC_W = 64;

    typedef struct packed {
        logic is_signed;
        logic accumulate;
        logic saturate;
    } mode_t;

    typedef struct packed {
        logic [MAX_ACC_W-1:0] d;
        logic                 ovf;
    } sat_res_t;

    function automatic int unsigned prod_w(input int unsigned in_w);
        return 2 * in_w + 2;
    endfunction

    function automatic int unsigned sum_w(input int unsigned in_w, input int unsigned k);
        return prod_w(in_w) + $clog2(k);
    endfunction

    // t is the exact sum sign-extended into the container; limits follow acc_w
    function automatic sat_res_t sat_trunc(input logic signed [MAX_ACC_W:0] t,
                                           input logic saturate,
                                           input int unsigned acc_w);
        logic signed [MAX_ACC_W:0] hi;
        logic signed [MAX_ACC_W:0] lo;
        sat_res_t r;
        hi = '0;
        hi[acc_w-1] = 1'b1;
        hi = hi - 1;
        lo = ~hi;
        r.ovf = (t > hi) || (t < lo);
        if (saturate && (t > hi))
            r.d = hi[MAX_ACC_W-1:0];
        else if (saturate && (t < lo))
            r.d = lo[MAX_ACC_W-1:0];
        else
            r.d = t[MAX_ACC_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/vx_tensor_int_dpu_if.sv
// Transaction bus of the tensor dot-product unit: input side and result side.
interface vx_tensor_int_dpu_if #(
    parameter int unsigned M     = 4,
    parameter int unsigned N     = 4,
    parameter int unsigned K     = 2,
    parameter int unsigned IN_W  = 8,
    parameter int unsigned ACC_W = 32,
    parameter int unsigned TAG_W = 8
) ();
    logic                   valid_in;
    logic                   ready_in;
    logic                   is_signed;
    logic                   accumulate;
    logic                   saturate;
    logic [TAG_W-1:0]       tag_in;
    logic [M*K*IN_W-1:0]    A_tile;
    logic [K*N*IN_W-1:0]    B_tile;
    logic [M*N*ACC_W-1:0]   C_tile;
    logic                   valid_out;
    logic                   ready_out;
    logic [TAG_W-1:0]       tag_out;
    logic [M*N*ACC_W-1:0]   D_tile;
    logic                   ovf_out;

    modport master (
        output valid_in, is_signed, accumulate, saturate, tag_in, A_tile, B_tile, C_tile, ready_out,
        input  ready_in, valid_out, tag_out, D_tile, ovf_out
    );

    modport slave (
        input  valid_in, is_signed, accumulate, saturate, tag_in, A_tile, B_tile, C_tile, ready_out,
        output ready_in, valid_out, tag_out, D_tile, ovf_out
    );
endinterface

// File: rtl/vx_tensor_pipe_stage.sv
// Elastic valid/ready register slice; ready passes through when the slot is full.
module vx_tensor_pipe_stage #(
    parameter int unsigned DATAW = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [DATAW-1:0] i_data,
    output logic             o_valid,
    output logic [DATAW-1:0] o_data,
    input  logic             i_ready
);
    logic             r_valid;
    logic [DATAW-1:0] r_data;

    assign o_ready = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid)
                r_data <= i_data;
        end
    end
endmodule

// File: rtl/vx_tensor_int_dpu.sv
// Integer tensor dot-product unit: D = A*B (+C), 3-stage elastic pipeline
// (multiply, reduction, C-add/clamp), modes and tag travel with each transaction.
module vx_tensor_int_dpu
    import vx_tensor_pkg::*;
#(
    parameter int unsigned M     = 4,
    parameter int unsigned N     = 4,
    parameter int unsigned K     = 2,
    parameter int unsigned IN_W  = 8,
    parameter int unsigned ACC_W = 32,
    parameter int unsigned TAG_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    vx_tensor_int_dpu_if.slave   bus
);
    localparam int unsigned PROD_W = prod_w(IN_W);
    localparam int unsigned SUM_W  = sum_w(IN_W, K);
    localparam int unsigned T_W    = ACC_W + 1;
    localparam int unsigned MODE_W = $bits(mode_t);
    localparam int unsigned S1_W   = M*N*K*PROD_W + M*N*ACC_W + MODE_W + TAG_W;
    localparam int unsigned S2_W   = M*N*SUM_W + M*N*ACC_W + MODE_W + TAG_W;
    localparam int unsigned S3_W   = M*N*ACC_W + 1 + TAG_W;

    mode_t w_mode_in;
    assign w_mode_in.is_signed  = bus.is_signed;
    assign w_mode_in.accumulate = bus.accumulate;
    assign w_mode_in.saturate   = bus.saturate;

    // S1: widen each operand by one bit so signed and unsigned share one signed multiplier
    logic [M*N*K*PROD_W-1:0] w_prod;
    logic signed [IN_W:0]    w_ea;
    logic signed [IN_W:0]    w_eb;
    always_comb begin
        w_prod = '0;
        w_ea   = '0;
        w_eb   = '0;
        for (int unsigned m = 0; m < M; m++)
            for (int unsigned n = 0; n < N; n++)
                for (int unsigned k = 0; k < K; k++) begin
                    w_ea = {w_mode_in.is_signed & bus.A_tile[(m*K+k)*IN_W + IN_W - 1],
                            bus.A_tile[(m*K+k)*IN_W +: IN_W]};
                    w_eb = {w_mode_in.is_signed & bus.B_tile[(k*N+n)*IN_W + IN_W - 1],
                            bus.B_tile[(k*N+n)*IN_W +: IN_W]};
                    w_prod[((m*N+n)*K+k)*PROD_W +: PROD_W] = PROD_W'(w_ea) * PROD_W'(w_eb);
                end
    end

    logic                    w_s1_ready, w_s1_valid;
    logic                    w_s2_ready, w_s2_valid;
    logic                    w_s3_ready;
    logic [S1_W-1:0]         w_s1_q;
    logic [M*N*K*PROD_W-1:0] w_s1_prod;
    logic [M*N*ACC_W-1:0]    w_s1_c;
    mode_t                   w_s1_mode;
    logic [TAG_W-1:0]        w_s1_tag;

    vx_tensor_pipe_stage #(.DATAW(S1_W)) u_s1 (
        .clk     (clk),
        .reset   (reset),
        .i_valid (bus.valid_in),
        .o_ready (w_s1_ready),
        .i_data  ({w_prod, bus.C_tile, w_mode_in, bus.tag_in}),
        .o_valid (w_s1_valid),
        .o_data  (w_s1_q),
        .i_ready (w_s2_ready)
    );
    assign bus.ready_in = w_s1_ready;
    assign {w_s1_prod, w_s1_c, w_s1_mode, w_s1_tag} = w_s1_q;

    // S2: exact reduction over k
    logic [M*N*SUM_W-1:0]    w_sum;
    logic signed [SUM_W-1:0] w_acc;
    always_comb begin
        w_sum = '0;
        w_acc = '0;
        for (int unsigned m = 0; m < M; m++)
            for (int unsigned n = 0; n < N; n++) begin
                w_acc = '0;
                for (int unsigned k = 0; k < K; k++)
                    w_acc = w_acc + SUM_W'($signed(w_s1_prod[((m*N+n)*K+k)*PROD_W +: PROD_W]));
                w_sum[(m*N+n)*SUM_W +: SUM_W] = w_acc;
            end
    end

    logic [S2_W-1:0]         w_s2_q;
    logic [M*N*SUM_W-1:0]    w_s2_sum;
    logic [M*N*ACC_W-1:0]    w_s2_c;
    mode_t                   w_s2_mode;
    logic [TAG_W-1:0]        w_s2_tag;

    vx_tensor_pipe_stage #(.DATAW(S2_W)) u_s2 (
        .clk     (clk),
        .reset   (reset),
        .i_valid (w_s1_valid),
        .o_ready (w_s2_ready),
        .i_data  ({w_sum, w_s1_c, w_s1_mode, w_s1_tag}),
        .o_valid (w_s2_valid),
        .o_data  (w_s2_q),
        .i_ready (w_s3_ready)
    );
    assign {w_s2_sum, w_s2_c, w_s2_mode, w_s2_tag} = w_s2_q;

    // S3: add C at ACC_W+1 bits, then clamp or wrap; overflow flag ignores saturate
    logic [M*N*ACC_W-1:0]  w_d;
    logic                  w_ovf;
    logic signed [T_W-1:0] w_t;
    sat_res_t              w_res;
    always_comb begin
        w_d   = '0;
        w_ovf = 1'b0;
        w_t   = '0;
        w_res = '0;
        for (int unsigned i = 0; i < M*N; i++) begin
            w_t = T_W'($signed(w_s2_sum[i*SUM_W +: SUM_W]));
            if (w_s2_mode.accumulate)
                w_t = w_t + T_W'($signed(w_s2_c[i*ACC_W +: ACC_W]));
            w_res = sat_trunc((MAX_ACC_W+1)'(w_t), w_s2_mode.saturate, ACC_W);
            w_d[i*ACC_W +: ACC_W] = ACC_W'(w_res.d);
            w_ovf = w_ovf | w_res.ovf;
        end
    end

    logic [S3_W-1:0] w_s3_q;

    vx_tensor_pipe_stage #(.DATAW(S3_W)) u_s3 (
        .clk     (clk),
        .reset   (reset),
        .i_valid (w_s2_valid),
        .o_ready (w_s3_ready),
        .i_data  ({w_d, w_ovf, w_s2_tag}),
        .o_valid (bus.valid_out),
        .o_data  (w_s3_q),
        .i_ready (bus.ready_out)
    );
    assign {bus.D_tile, bus.ovf_out, bus.tag_out} = w_s3_q;

endmodule

// File: tb/tb_vx_tensor_int_dpu.sv
// Directed self-checking bench for vx_tensor_int_dpu (M=N=4, K=2, IN_W=8, ACC_W=32).
module tb_vx_tensor_int_dpu;
    localparam int unsigned M     = 4;
    localparam int unsigned N     = 4;
    localparam int unsigned K     = 2;
    localparam int unsigned IN_W  = 8;
    localparam int unsigned ACC_W = 32;
    localparam int unsigned TAG_W = 8;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    vx_tensor_int_dpu_if #(.M(M), .N(N), .K(K), .IN_W(IN_W), .ACC_W(ACC_W), .TAG_W(TAG_W)) bus ();

    vx_tensor_int_dpu #(.M(M), .N(N), .K(K), .IN_W(IN_W), .ACC_W(ACC_W), .TAG_W(TAG_W)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_txn(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b,
                             input logic [ACC_W-1:0] c, input logic sg, input logic ac,
                             input logic sa, input logic [TAG_W-1:0] tag);
        for (int i = 0; i < M*K; i++) bus.A_tile[i*IN_W +: IN_W] = a;
        for (int i = 0; i < K*N; i++) bus.B_tile[i*IN_W +: IN_W] = b;
        for (int i = 0; i < M*N; i++) bus.C_tile[i*ACC_W +: ACC_W] = c;
        bus.is_signed  = sg;
        bus.accumulate = ac;
        bus.saturate   = sa;
        bus.tag_in     = tag;
        bus.valid_in   = 1'b1;
    endtask

    // called right after the transfer-in edge; lat counts cycles until valid_out
    task automatic wait_out(output int lat, output bit ok);
        lat = 1;
        while (!bus.valid_out && lat < 20) begin
            tick();
            lat++;
        end
        ok = bus.valid_out;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        n_checks++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid_out: got %b expected 0", bus.valid_out); end
        n_checks++; if (bus.tag_out !== '0) begin n_fail++; $display("FAIL reset_tag_out: got %h expected 00", bus.tag_out); end
        n_checks++; if (bus.D_tile !== '0) begin n_fail++; $display("FAIL reset_D_tile: got nonzero expected 0"); end
        n_checks++; if (bus.ovf_out !== 1'b0) begin n_fail++; $display("FAIL reset_ovf_out: got %b expected 0", bus.ovf_out); end
        n_checks++; if (bus.ready_in !== 1'b1) begin n_fail++; $display("FAIL reset_ready_in: got %b expected 1", bus.ready_in); end
    endtask

    task automatic test_unsigned();
        int lat; bit ok;
        bus.ready_out = 1'b1;
        drive_txn(8'd255, 8'd255, 32'd12345, 1'b0, 1'b0, 1'b0, 8'h11);
        tick();
        bus.valid_in = 1'b0;
        wait_out(lat, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL unsigned_timeout: got no valid_out expected valid_out"); end
        n_checks++; if (lat != 3) begin n_fail++; $display("FAIL unsigned_latency: got %0d expected 3", lat); end
        for (int i = 0; i < M*N; i++) begin
            n_checks++;
            if (bus.D_tile[i*ACC_W +: ACC_W] !== 32'd130050) begin
                n_fail++; $display("FAIL unsigned_D[%0d]: got %0d expected 130050", i, $signed(bus.D_tile[i*ACC_W +: ACC_W]));
            end
        end
        n_checks++; if (bus.ovf_out !== 1'b0) begin n_fail++; $display("FAIL unsigned_ovf: got %b expected 0", bus.ovf_out); end
        n_checks++; if (bus.tag_out !== 8'h11) begin n_fail++; $display("FAIL unsigned_tag: got %h expected 11", bus.tag_out); end
        tick();
        n_checks++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL unsigned_drain: got %b expected 0", bus.valid_out); end
    endtask

    task automatic test_signed_acc();
        int lat; bit ok;
        logic [ACC_W-1:0] exp_d;
        exp_d = -31512;
        drive_txn(8'h80, 8'd127, 32'd1000, 1'b1, 1'b1, 1'b0, 8'h22);
        tick();
        bus.valid_in = 1'b0;
        wait_out(lat, ok);
        n_checks++; if (!ok || lat != 3) begin n_fail++; $display("FAIL signed_latency: got %0d (valid %b) expected 3", lat, ok); end
        for (int i = 0; i < M*N; i++) begin
            n_checks++;
            if (bus.D_tile[i*ACC_W +: ACC_W] !== exp_d) begin
                n_fail++; $display("FAIL signed_D[%0d]: got %0d expected -31512", i, $signed(bus.D_tile[i*ACC_W +: ACC_W]));
            end
        end
        n_checks++; if (bus.ovf_out !== 1'b0) begin n_fail++; $display("FAIL signed_ovf: got %b expected 0", bus.ovf_out); end
        tick();
    endtask

    task automatic test_saturate();
        int lat; bit ok;
        logic [ACC_W-1:0] exp_d;
        for (int s = 1; s >= 0; s--) begin
            exp_d = (s == 1) ? 32'h7FFF_FFFF : 32'h8000_0001;
            drive_txn(8'd1, 8'd1, 32'h7FFF_FFFF, 1'b1, 1'b1, s[0], 8'(8'h30 + s));
            tick();
            bus.valid_in = 1'b0;
            wait_out(lat, ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL sat%0d_timeout: got no valid_out expected valid_out", s); end
            n_checks++; if (bus.D_tile[0 +: ACC_W] !== exp_d) begin n_fail++; $display("FAIL sat%0d_D0: got %0d expected %0d", s, $signed(bus.D_tile[0 +: ACC_W]), $signed(exp_d)); end
            n_checks++; if (bus.D_tile[(M*N-1)*ACC_W +: ACC_W] !== exp_d) begin n_fail++; $display("FAIL sat%0d_Dlast: got %0d expected %0d", s, $signed(bus.D_tile[(M*N-1)*ACC_W +: ACC_W]), $signed(exp_d)); end
            n_checks++; if (bus.ovf_out !== 1'b1) begin n_fail++; $display("FAIL sat%0d_ovf: got %b expected 1", s, bus.ovf_out); end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int sent = 0;
        int got  = 0;
        bit in_fire, out_fire;
        logic [TAG_W-1:0] q[$];
        drive_txn(8'd0, 8'd0, 32'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
            bus.ready_out = (cyc >= 6);
            bus.valid_in  = (sent < 10);
            bus.tag_in    = 8'(sent);
            #1;
            in_fire  = bus.valid_in && bus.ready_in;
            out_fire = bus.valid_out && bus.ready_out;
            if (cyc == 3) begin
                n_checks++; if (bus.ready_in !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full: got %b expected 0", bus.ready_in); end
                n_checks++; if (sent != 3) begin n_fail++; $display("FAIL bp_accepts: got %0d expected 3", sent); end
            end
            if (cyc == 6) begin
                n_checks++; if (bus.ready_in !== 1'b1) begin n_fail++; $display("FAIL bp_ready_passthru: got %b expected 1", bus.ready_in); end
            end
            if (out_fire) q.push_back(bus.tag_out);
            @(posedge clk);
            #1;
            if (in_fire) sent++;
            if (out_fire) got++;
        end
        bus.valid_in = 1'b0;
        n_checks++; if (q.size() != 10) begin n_fail++; $display("FAIL bp_count: got %0d expected 10", q.size()); end
        for (int i = 0; i < 10 && i < q.size(); i++) begin
            n_checks++; if (q[i] !== 8'(i)) begin n_fail++; $display("FAIL bp_tag[%0d]: got %0d expected %0d", i, q[i], i); end
        end
        tick();
        n_checks++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup: got %b expected 0", bus.valid_out); end
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int got  = 0;
        bit in_fire, out_fire;
        int oc[6];
        logic [ACC_W-1:0] d0[6];
        logic [ACC_W-1:0] dl[6];
        logic [ACC_W-1:0] exp_d;
        bus.ready_out = 1'b1;
        drive_txn(8'd0, 8'd0, 32'd5, 1'b1, 1'b0, 1'b0, 8'd0);
        bus.valid_in = 1'b0;
        for (int cyc = 0; cyc < 30 && got < 6; cyc++) begin
            bus.valid_in   = (sent < 6);
            bus.accumulate = sent[0];
            bus.tag_in     = 8'(sent);
            #1;
            in_fire  = bus.valid_in && bus.ready_in;
            out_fire = bus.valid_out && bus.ready_out;
            if (out_fire) begin
                oc[got] = cyc;
                d0[got] = bus.D_tile[0 +: ACC_W];
                dl[got] = bus.D_tile[(M*N-1)*ACC_W +: ACC_W];
            end
            @(posedge clk);
            #1;
            if (in_fire) sent++;
            if (out_fire) got++;
        end
        bus.valid_in = 1'b0;
        n_checks++; if (got != 6) begin n_fail++; $display("FAIL b2b_count: got %0d expected 6", got); end
        for (int i = 0; i < got; i++) begin
            exp_d = (i % 2 == 1) ? 32'd5 : 32'd0;
            n_checks++; if (oc[i] != 3 + i) begin n_fail++; $display("FAIL b2b_cycle[%0d]: got %0d expected %0d", i, oc[i], 3 + i); end
            n_checks++; if (d0[i] !== exp_d) begin n_fail++; $display("FAIL b2b_D0[%0d]: got %0d expected %0d", i, d0[i], exp_d); end
            n_checks++; if (dl[i] !== exp_d) begin n_fail++; $display("FAIL b2b_Dlast[%0d]: got %0d expected %0d", i, dl[i], exp_d); end
        end
    endtask

    task automatic test_reset_midflight();
        int lat; bit ok;
        bus.ready_out = 1'b1;
        drive_txn(8'd0, 8'd0, 32'd7, 1'b0, 1'b1, 1'b0, 8'hAA);
        tick();
        bus.tag_in = 8'hBB;
        tick();
        bus.valid_in = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid: got %b expected 0", bus.valid_out); end
        n_checks++; if (bus.D_tile !== '0) begin n_fail++; $display("FAIL mid_reset_D: got nonzero expected 0"); end
        n_checks++; if (bus.ready_in !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ready: got %b expected 1", bus.ready_in); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL mid_stale[%0d]: got %b expected 0", i, bus.valid_out); end
        end
        drive_txn(8'd0, 8'd0, 32'd9, 1'b0, 1'b1, 1'b0, 8'hCC);
        tick();
        bus.valid_in = 1'b0;
        wait_out(lat, ok);
        n_checks++; if (!ok || lat != 3) begin n_fail++; $display("FAIL mid_next_latency: got %0d (valid %b) expected 3", lat, ok); end
        n_checks++; if (bus.D_tile[0 +: ACC_W] !== 32'd9) begin n_fail++; $display("FAIL mid_next_D0: got %0d expected 9", bus.D_tile[0 +: ACC_W]); end
        n_checks++; if (bus.tag_out !== 8'hCC) begin n_fail++; $display("FAIL mid_next_tag: got %h expected cc", bus.tag_out); end
        tick();
    endtask

    initial begin
        reset          = 1'b1;
        bus.valid_in   = 1'b0;
        bus.ready_out  = 1'b1;
        bus.is_signed  = 1'b0;
        bus.accumulate = 1'b0;
        bus.saturate   = 1'b0;
        bus.tag_in     = '0;
        bus.A_tile     = '0;
        bus.B_tile     = '0;
        bus.C_tile     = '0;
        test_reset();
        test_unsigned();
        test_signed_acc();
        test_saturate();
        test_backpressure();
        test_back_to_back();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
